// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator with registered, zero-skew address,
//                sync, data-enable and line/frame strobe outputs.
//                Optional frame counter built when VGA_TIMING_FRAME_CNT_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               pix_ce,
    output logic [CW-1:0]      haddr,
    output logic [CW-1:0]      vaddr,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive upper bounds keep every constant representable in CW bits,
    // even when a total is exactly 2**CW.
    localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act_last = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] c_v_act_last = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] c_hs_first   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_last    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_vs_first   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_last    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] r_haddr;
    logic [CW-1:0] r_vaddr;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_frame_wrap;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_hs_nxt;
    logic          w_vs_nxt;
    logic          w_de_nxt;

    always_comb begin
        w_h_wrap     = (r_haddr == c_h_last);
        w_v_wrap     = (r_vaddr == c_v_last);
        w_frame_wrap = w_h_wrap & w_v_wrap;

        w_h_nxt = w_h_wrap ? '0 : r_haddr + 1'b1;
        w_v_nxt = r_vaddr;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_vaddr + 1'b1;
        end

        // Levels are decoded from the next address so they land in the same
        // register stage as the address they describe.
        w_hs_nxt = ((w_h_nxt >= c_hs_first) && (w_h_nxt <= c_hs_last)) ? HSYNC_POL : ~HSYNC_POL;
        w_vs_nxt = ((w_v_nxt >= c_vs_first) && (w_v_nxt <= c_vs_last)) ? VSYNC_POL : ~VSYNC_POL;
        w_de_nxt = (w_h_nxt <= c_h_act_last) && (w_v_nxt <= c_v_act_last);
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_haddr       <= '0;
            r_vaddr       <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes are recomputed every clk, so they drop after one cycle
            // even when pix_ce stays low for a while after a wrap.
            r_line_start  <= pix_ce & w_h_wrap;
            r_frame_start <= pix_ce & w_frame_wrap;
            if (pix_ce) begin
                r_haddr <= w_h_nxt;
                r_vaddr <= w_v_nxt;
                r_hsync <= w_hs_nxt;
                r_vsync <= w_vs_nxt;
                r_de    <= w_de_nxt;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_frame_cnt <= '0;
        end else if (pix_ce & w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

    assign haddr       = r_haddr;
    assign vaddr       = r_vaddr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Scoreboard bench for vga_timing_gen; two small rasters (one
//                with inverted sync polarity) against a linear pixel-index model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int de;
        int ls;
        int fs;
        int fc;
    } exp_t;

    // Raster A: 15 x 8, active-low syncs. Raster B: 10 x 7, active-high syncs.
    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam int B_HA = 6, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VA = 3, B_VF = 1, B_VS = 1, B_VB = 2;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_FT = A_HT * (A_VA + A_VF + A_VS + A_VB);
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_FT = B_HT * (B_VA + B_VF + B_VS + B_VB);
    localparam int NCYC = 3000;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       pix_ce;

    logic [4:0] a_haddr, a_vaddr;
    logic       a_hsync, a_vsync, a_de, a_ls, a_fs;
    logic [1:0] a_fc;
    logic [3:0] b_haddr, b_vaddr;
    logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
    logic [1:0] b_fc;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];

    int pa, pb, fca, fcb;
    bit lsa, fsa, lsb, fsb;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(5), .FRAME_W(2)
    ) u_dut_a (
        .clk(clk), .sys_rst(sys_rst), .pix_ce(pix_ce),
        .haddr(a_haddr), .vaddr(a_vaddr), .hsync(a_hsync), .vsync(a_vsync),
        .de(a_de), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4), .FRAME_W(2)
    ) u_dut_b (
        .clk(clk), .sys_rst(sys_rst), .pix_ce(pix_ce),
        .haddr(b_haddr), .vaddr(b_vaddr), .hsync(b_hsync), .vsync(b_vsync),
        .de(b_de), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs from the linear pixel index p within the frame.
    function automatic exp_t calc(input int p, input bit ls, input bit fs, input int fc,
                                  input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw,
                                  input bit hp, input bit vp);
        exp_t e;
        int   ht;
        ht   = ha + hf + hsw + hb;
        e.h  = p % ht;
        e.v  = p / ht;
        e.hs = (e.h >= ha + hf && e.h < ha + hf + hsw) ? int'(hp) : int'(!hp);
        e.vs = (e.v >= va + vf && e.v < va + vf + vsw) ? int'(vp) : int'(!vp);
        e.de = (e.h < ha && e.v < va) ? 1 : 0;
        e.ls = int'(ls);
        e.fs = int'(fs);
        e.fc = fc;
        return e;
    endfunction

    task automatic step(input bit pce, input int ht, input int ft,
                        inout int p, inout int fc, output bit ls, output bit fs);
        ls = 1'b0;
        fs = 1'b0;
        if (pce) begin
            ls = ((p % ht) == ht - 1);
            fs = (p == ft - 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (fs) fc = (fc + 1) % 4;
`endif
            p = (p + 1) % ft;
        end
    endtask

    task automatic push_exp();
        qa.push_back(calc(pa, lsa, fsa, fca, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, 1'b0, 1'b0));
        qb.push_back(calc(pb, lsb, fsb, fcb, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, 1'b1, 1'b1));
    endtask

    task automatic model_reset();
        pa = 0; pb = 0; fca = 0; fcb = 0;
        lsa = 1'b0; fsa = 1'b0; lsb = 1'b0; fsb = 1'b0;
    endtask

    task automatic chk_inst(input string pf, input exp_t e, input int h, input int v,
                            input int hs, input int vs, input int de,
                            input int ls, input int fs, input int fc);
        chk({pf, ".haddr"}, h, e.h);
        chk({pf, ".vaddr"}, v, e.v);
        chk({pf, ".hsync"}, hs, e.hs);
        chk({pf, ".vsync"}, vs, e.vs);
        chk({pf, ".de"}, de, e.de);
        chk({pf, ".line_start"}, ls, e.ls);
        chk({pf, ".frame_start"}, fs, e.fs);
        chk({pf, ".frame_cnt"}, fc, e.fc);
    endtask

    // Monitor: one registered output set per clk, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk_inst("A", e, int'(a_haddr), int'(a_vaddr), int'(a_hsync), int'(a_vsync),
                         int'(a_de), int'(a_ls), int'(a_fs), int'(a_fc));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk_inst("B", e, int'(b_haddr), int'(b_vaddr), int'(b_hsync), int'(b_vsync),
                         int'(b_de), int'(b_ls), int'(b_fs), int'(b_fc));
            end
        end
    end

    // Driver: choose inputs each negedge and push the response due at the next posedge.
    initial begin
        exp_t r;
        sys_rst = 1'b1;
        pix_ce  = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
        sys_rst = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 1700 || cyc == 2400) begin
                // Asynchronous reset mid-frame: outputs must clear before any clk edge.
                #1 sys_rst = 1'b1;
                #1;
                r = calc(0, 1'b0, 1'b0, 0, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, 1'b0, 1'b0);
                chk_inst("A.async_rst", r, int'(a_haddr), int'(a_vaddr), int'(a_hsync), int'(a_vsync),
                         int'(a_de), int'(a_ls), int'(a_fs), int'(a_fc));
                r = calc(0, 1'b0, 1'b0, 0, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, 1'b1, 1'b1);
                chk_inst("B.async_rst", r, int'(b_haddr), int'(b_vaddr), int'(b_hsync), int'(b_vsync),
                         int'(b_de), int'(b_ls), int'(b_fs), int'(b_fc));
                model_reset();
                push_exp();
                @(negedge clk);
                sys_rst = 1'b0;
            end else begin
                if (cyc >= 1000 && cyc < 1400)
                    pix_ce = cyc[0];
                else if (cyc >= 1400 && cyc < 1600)
                    pix_ce = 1'b1;
                else
                    pix_ce = ($urandom_range(0, 3) != 0);
                step(pix_ce, A_HT, A_FT, pa, fca, lsa, fsa);
                step(pix_ce, B_HT, B_FT, pb, fcb, lsb, fsb);
                push_exp();
                @(negedge clk);
            end
        end
        @(posedge clk);
        #4;
        chk("queue_drain", qa.size() + qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480/10/2/33, vertical equivalents in lines.
REQ-006 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0, sync asserted level (0 = active-low).
REQ-007 SHALL have parameter CW, default 10, counter width; CW >= clog2 of both totals.
REQ-008 SHALL have parameter FRAME_W, default 8, frame counter width.
REQ-009 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-010 SHALL have port sys_rst, input, 1, reset: asynchronous, active-high.
REQ-011 SHALL have port pix_ce, input, 1, pixel advance enable.
REQ-012 SHALL have ports haddr and vaddr, output, CW each, current pixel column and line.
REQ-013 SHALL have ports hsync and vsync, output, 1 each, sync outputs at configured polarity.
REQ-014 SHALL have port de, output, 1, high while the current pixel is visible.
REQ-015 SHALL have ports line_start and frame_start, output, 1 each, single-clk strobes.
REQ-016 SHALL have port frame_cnt, output, FRAME_W, completed-frame count.
REQ-017 All outputs SHALL be registered.

Function
REQ-018 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
REQ-019 On a clk edge with pix_ce=1, haddr SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vaddr SHALL increment.
REQ-020 vaddr at V_TOTAL-1 with haddr wrapping SHALL wrap to 0; no value >= total SHALL ever appear.
REQ-021 With pix_ce=0, every counter and level output SHALL hold.
REQ-022 hsync, vsync and de SHALL describe the haddr/vaddr values presented in the same cycle (zero skew).
REQ-023 hsync SHALL be at HSYNC_POL exactly while haddr in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else its inverse.
REQ-024 vsync SHALL be at VSYNC_POL exactly while vaddr in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
REQ-025 de SHALL be 1 exactly while haddr < H_ACTIVE and vaddr < V_ACTIVE.
REQ-026 line_start SHALL be 1 for exactly one clk cycle in the cycle the outputs first show haddr=0 after a wrap.
REQ-027 frame_start SHALL be 1 for exactly one clk cycle in the cycle the outputs first show (0,0) after a frame wrap; line_start also asserts then.
REQ-028 Strobes SHALL be one clk wide regardless of pix_ce duty.

Reset
REQ-029 While sys_rst=1: haddr=0, vaddr=0, de=1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, line_start=0, frame_start=0, frame_cnt=0.
REQ-030 Reset SHALL take effect immediately, mid-line or mid-frame; release SHALL resume from (0,0) with no strobe for the first frame.

Configuration
REQ-031 With macro VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment modulo 2^FRAME_W on every frame_start.
REQ-032 Without VGA_TIMING_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-033 Defaults, pix_ce=1: hsync low for haddr 656..751 (96 clks), line period 800 clks, haddr never reaches 800.
REQ-034 Defaults, pix_ce=1: vsync low on lines 490..491 (1600 clks), frame period 420000 clks, frame_start every 420000 clks.
REQ-035 pix_ce toggling 1/0: line period 1600 clks, line_start 1 clk wide, counters hold on pix_ce=0 cycles.
REQ-036 HSYNC_POL=1, VSYNC_POL=1: sync polarities inverted, reset levels 0, de unchanged.
REQ-037 sys_rst pulsed at (haddr=300, vaddr=200): outputs at reset values without waiting for clk; restart at (0,0), next frame_start after 420000 clks.
REQ-038 VGA_TIMING_FRAME_CNT_EN, FRAME_W=2: frame_cnt 1,2,3,0 after four frames; without macro frame_cnt stays 0.
